// File: rtl/fsm.sv
// fsm: memory control state machine
// sel/op decode to registered valid strobe and rw direction
module fsm (
  input  logic clk,
  input  logic reset,
  input  logic op,
  input  logic sel,
  output logic valid,
  output logic rw
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    READ   = 2'b01,
    WRITE  = 2'b10,
    STABLE = 2'b11
  } state_t;

  state_t state;

  function automatic state_t nxt(
    input state_t s,
    input logic   sl,
    input logic   o
  );
    state_t n;
    n = IDLE;
    if (sl === 1'b1) begin
      case (s)
        IDLE, READ, STABLE: begin
          case (o)
            1'b0:    n = READ;
            1'b1:    n = WRITE;
            default: n = IDLE;
          endcase
        end
        WRITE:   n = STABLE;
        default: n = IDLE;
      endcase
    end
    return n;
  endfunction

  function automatic logic fvalid(input state_t s);
    return (s == READ) || (s == WRITE);
  endfunction

  function automatic logic frw(input state_t s);
    return (s == WRITE) || (s == STABLE);
  endfunction

  // State and outputs registered together; outputs track the new state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
      rw    <= 1'b0;
    end else begin
      state <= nxt(state, sel, op);
      valid <= fvalid(nxt(state, sel, op));
      rw    <= frw(nxt(state, sel, op));
    end
  end

endmodule

// File: tb/tb_fsm.sv
// tb_fsm: directed test for fsm
// inputs change between edges, outputs sampled off-edge
module tb_fsm;

  logic clk;
  logic reset;
  logic op;
  logic sel;
  logic valid;
  logic rw;

  int n_chk;
  int n_fail;

  fsm dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .sel   (sel),
    .valid (valid),
    .rw    (rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic  ev,
    input logic  er
  );
    n_chk++;
    assert (valid === ev && rw === er)
    else begin
      n_fail++;
      $error("FAIL %s: valid=%b rw=%b, want valid=%b rw=%b",
             tag, valid, rw, ev, er);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    op     = 1'b0;
    sel    = 1'b0;

    #1;
    chk("rst_async", 1'b0, 1'b0);
    #19;
    chk("rst_held", 1'b0, 1'b0);
    reset = 1'b0;
    #10;
    chk("idle_sel0", 1'b0, 1'b0);
    sel = 1'b1;
    op  = 1'b0;
    #10;
    chk("read_1", 1'b1, 1'b0);
    #10;
    chk("read_hold", 1'b1, 1'b0);
    op = 1'b1;
    #10;
    chk("rd_to_wr", 1'b1, 1'b1);
    #10;
    chk("stable_1", 1'b0, 1'b1);
    #10;
    chk("write_2", 1'b1, 1'b1);
    sel = 1'b0;
    op  = 1'b0;
    #10;
    chk("wr_sel0_idle", 1'b0, 1'b0);
    #10;
    chk("idle_hold", 1'b0, 1'b0);
    sel = 1'b1;
    op  = 1'b1;
    #10;
    chk("idle_to_wr", 1'b1, 1'b1);
    op = 1'b0;
    #10;
    chk("wr_op0_stable", 1'b0, 1'b1);
    #10;
    chk("stable_to_rd", 1'b1, 1'b0);
    op = 1'b1;
    #10;
    chk("write_3", 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_midcycle", 1'b0, 1'b0);
    #7;
    chk("rst_over_edge", 1'b0, 1'b0);
    reset = 1'b0;
    #10;
    chk("post_rst_wr", 1'b1, 1'b1);
    #10;
    chk("stable_2", 1'b0, 1'b1);
    sel = 1'b0;
    #10;
    chk("stable_sel0", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
